// File: rtl/led_strip_pkg.sv
// Shared types, timing defaults and pixel helpers for the LED strip transmitter.
// The gamma helper exists only when LED_STRIP_GAMMA_EN is defined.
package led_strip_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift,
        StLatch
    } led_state_e;

    localparam int unsigned DEF_NUM_LEDS = 256;
    localparam int unsigned DEF_T0H      = 20;
    localparam int unsigned DEF_T1H      = 40;
    localparam int unsigned DEF_TBIT     = 63;
    localparam int unsigned DEF_TLATCH   = 15000;
    localparam int unsigned PIXEL_BITS   = 24;

    // RGB565 -> GRB888, low bits filled by replicating the channel MSBs
    function automatic logic [23:0] rgb565_to_grb(input logic [15:0] px);
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        r8 = {px[15:11], px[15:13]};
        g8 = {px[10:5], px[10:9]};
        b8 = {px[4:0], px[4:2]};
        return {g8, r8, b8};
    endfunction

`ifdef LED_STRIP_GAMMA_EN
    // floor(255 * (x/255)^2.2), found as the largest y with y^5 * 255^6 <= x^11
    function automatic logic [7:0] gamma22(input int unsigned x);
        logic [95:0] num;
        logic [95:0] den;
        logic [95:0] p;
        logic [7:0]  y;
        logic [7:0]  t;
        num = 96'd1;
        den = 96'd1;
        for (int i = 0; i < 11; i++) num = num * 96'(x);
        for (int i = 0; i < 6; i++) den = den * 96'd255;
        y = 8'd0;
        for (int b = 7; b >= 0; b--) begin
            t = y | (8'd1 << b);
            p = 96'(t);
            p = p * p * p * p * p * den;
            if (p <= num) y = t;
        end
        return y;
    endfunction
`endif

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single NRZ bit generator: on go, drives one TBIT-long period high for T0H/T1H cycles,
// strobing bit_done in the last cycle so a new go there yields a gapless stream.
module ws2812_bit_tx
    import led_strip_pkg::*;
#(
    parameter int unsigned T0H  = DEF_T0H,
    parameter int unsigned T1H  = DEF_T1H,
    parameter int unsigned TBIT = DEF_TBIT
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic go,
    input  logic bit_val,
    output logic dout,
    output logic bit_done
);

    localparam int unsigned CW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HIGH0    = CW'(T0H);
    localparam logic [CW-1:0] HIGH1    = CW'(T1H);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          val_q, val_d;
    logic          dout_q, dout_d;

    assign bit_done = run_q && (cnt_q == CNT_LAST);
    assign dout     = dout_q;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        val_d = val_q;
        if (go) begin
            cnt_d = '0;
            run_d = 1'b1;
            val_d = bit_val;
        end else if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Output is registered from next-state so the line never glitches
        dout_d = run_d && (cnt_d < (val_d ? HIGH1 : HIGH0));
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            val_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            val_q  <= val_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/led_strip_tx.sv
// Strip buffer reader: fetches NUM_LEDS pixels per frame and streams them as WS2812 NRZ.
// Define LED_STRIP_GAMMA_EN to pass each expanded channel through a gamma-2.2 LUT.
module led_strip_tx
    import led_strip_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
    parameter int unsigned T0H      = DEF_T0H,
    parameter int unsigned T1H      = DEF_T1H,
    parameter int unsigned TBIT     = DEF_TBIT,
    parameter int unsigned TLATCH   = DEF_TLATCH
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        re,
    output logic [7:0]  raddr,
    input  logic [19:0] rdata,
    output logic        led_dout
);

    localparam int unsigned LW = (TLATCH > 1) ? $clog2(TLATCH) : 1;
    localparam logic [LW-1:0] LCNT_LAST = LW'(TLATCH - 1);
    localparam logic [8:0]    LAST_PIX  = 9'(NUM_LEDS - 1);
    localparam logic [4:0]    LAST_BIT  = 5'(PIXEL_BITS - 1);

    led_state_e    state_q, state_d;
    logic          re_q, re_d;
    logic          re_dly_q;
    logic [7:0]    raddr_q, raddr_d;
    logic [23:0]   sreg_q, sreg_d;
    logic [23:0]   next_q, next_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [8:0]    pix_q, pix_d;
    logic [8:0]    pix_nxt;
    logic [7:0]    raddr_pf;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          done_q, done_d;
    logic          go;
    logic          bit_val;
    logic          bit_done;
    logic [23:0]   pix_lin;
    logic [23:0]   pix_word;
    logic [3:0]    unused_rdata;

    assign unused_rdata = rdata[19:16];
    assign pix_lin      = rgb565_to_grb(rdata[15:0]);
    assign pix_nxt      = pix_q + 9'd1;
    assign raddr_pf     = pix_q[7:0] + 8'd2;

`ifdef LED_STRIP_GAMMA_EN
    logic [7:0] gamma_rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_gamma
        localparam logic [7:0] GV = gamma22(gi);
        assign gamma_rom[gi] = GV;
    end

    assign pix_word = {gamma_rom[pix_lin[23:16]], gamma_rom[pix_lin[15:8]],
                       gamma_rom[pix_lin[7:0]]};
`else
    assign pix_word = pix_lin;
`endif

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign re    = re_q;
    assign raddr = raddr_q;

    always_comb begin
        state_d   = state_q;
        re_d      = 1'b0;
        raddr_d   = raddr_q;
        sreg_d    = sreg_q;
        next_d    = next_q;
        bit_idx_d = bit_idx_q;
        pix_d     = pix_q;
        lcnt_d    = lcnt_q;
        done_d    = 1'b0;
        go        = 1'b0;
        bit_val   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done_q marks the return cycle; a start coinciding with it is dropped
                if (start && !done_q) begin
                    state_d = StFetch;
                    re_d    = 1'b1;
                    raddr_d = 8'd0;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                sreg_d    = pix_word;
                bit_idx_d = 5'd0;
                pix_d     = 9'd0;
                go        = 1'b1;
                bit_val   = pix_word[23];
                state_d   = StShift;
                if (LAST_PIX != 9'd0) begin
                    re_d    = 1'b1;
                    raddr_d = 8'd1;
                end
            end
            StShift: begin
                if (re_dly_q) begin
                    next_d = pix_word;
                end
                if (bit_done) begin
                    if (bit_idx_q != LAST_BIT) begin
                        sreg_d    = {sreg_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q + 5'd1;
                        go        = 1'b1;
                        bit_val   = sreg_q[22];
                    end else if (pix_q != LAST_PIX) begin
                        // Next pixel starts in the same cycle the last bit ends
                        sreg_d    = next_q;
                        bit_idx_d = 5'd0;
                        pix_d     = pix_nxt;
                        go        = 1'b1;
                        bit_val   = next_q[23];
                        if (pix_nxt != LAST_PIX) begin
                            re_d    = 1'b1;
                            raddr_d = raddr_pf;
                        end
                    end else begin
                        state_d = StLatch;
                        lcnt_d  = '0;
                    end
                end
            end
            StLatch: begin
                if (lcnt_q == LCNT_LAST) begin
                    state_d = StIdle;
                    lcnt_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            re_q      <= 1'b0;
            re_dly_q  <= 1'b0;
            raddr_q   <= 8'd0;
            sreg_q    <= 24'd0;
            next_q    <= 24'd0;
            bit_idx_q <= 5'd0;
            pix_q     <= 9'd0;
            lcnt_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            re_q      <= re_d;
            re_dly_q  <= re_q;
            raddr_q   <= raddr_d;
            sreg_q    <= sreg_d;
            next_q    <= next_d;
            bit_idx_q <= bit_idx_d;
            pix_q     <= pix_d;
            lcnt_q    <= lcnt_d;
            done_q    <= done_d;
        end
    end

    ws2812_bit_tx #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_tx (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .go       (go),
        .bit_val  (bit_val),
        .dout     (led_dout),
        .bit_done (bit_done)
    );

endmodule
